// File: rtl/usb_tx_arb_pkg.sv
// Shared types and default endpoint/FIFO constants for the USB IN arbiter.
package usb_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DAP  = 2'd1,
    ST_CDC  = 2'd2
  } arb_state_e;

  localparam logic [3:0]  DEF_DAP_EP      = 4'd2;
  localparam logic [3:0]  DEF_CDC_EP      = 4'd3;
  localparam int          DEF_CDC_DEPTH   = 64;
  localparam logic [11:0] DEF_CDC_MAX_PKT = 12'd64;

endpackage

// File: rtl/cdc_tx_fifo.sv
// CDC receive byte FIFO: committed read pointer plus a speculative shadow
// pointer so an un-acknowledged IN packet can be rewound and resent.
module cdc_tx_fifo
  import usb_tx_arb_pkg::*;
#(
  parameter int DEPTH = DEF_CDC_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  input  logic                     commit,
  input  logic [11:0]              commit_cnt,
  input  logic                     rewind,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] shadow_ptr_q, shadow_ptr_d;
  logic [AW-1:0] shadow_adv;
  logic [LW-1:0] level_q, level_d;
  logic          drop_q, drop_d;
  logic          full, push_ok;

  always_comb begin
    full         = (level_q == LW'(DEPTH));
    push_ok      = push & ~full;
    drop_d       = push & full;
    shadow_adv   = pop ? shadow_ptr_q + AW'(1) : shadow_ptr_q;
    wr_ptr_d     = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    shadow_ptr_d = shadow_adv;
    level_d      = level_q + LW'(push_ok);
    // commit_cnt already includes a pop landing in the commit cycle
    if (commit) begin
      rd_ptr_d = shadow_adv;
      level_d  = level_q + LW'(push_ok) - LW'(commit_cnt);
    end else if (rewind) begin
      shadow_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      shadow_ptr_q <= '0;
      level_q      <= '0;
      drop_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      shadow_ptr_q <= shadow_ptr_d;
      level_q      <= level_d;
      drop_q       <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign rd_data = mem_q[shadow_ptr_q];
  assign level   = level_q;
  assign drop    = drop_q;

endmodule

// File: rtl/usb_tx_arbiter.sv
// Multiplexes the DAP response source and the CDC receive FIFO onto the
// USB core's IN data path, one packet at a time.
module usb_tx_arbiter
  import usb_tx_arb_pkg::*;
#(
  parameter logic [3:0]  DAP_EP      = DEF_DAP_EP,
  parameter logic [3:0]  CDC_EP      = DEF_CDC_EP,
  parameter int          CDC_DEPTH   = DEF_CDC_DEPTH,
  parameter logic [11:0] CDC_MAX_PKT = DEF_CDC_MAX_PKT
) (
  input  logic                         hclk,
  input  logic                         hreset,
  input  logic [3:0]                   usb_endpt,
  input  logic                         usb_txact,
  input  logic                         usb_txpop,
  input  logic                         usb_txpktfin,
  output logic                         usb_txcork,
  output logic [7:0]                   usb_txdata,
  output logic [11:0]                  usb_txlen,
  input  logic                         dap_tvalid,
  input  logic [7:0]                   dap_tdata,
  input  logic [11:0]                  dap_tlen,
  output logic                         dap_tready,
  output logic                         dap_pktdone,
  input  logic                         cdc_in_tvalid,
  input  logic [7:0]                   cdc_in_tdata,
  output logic                         cdc_drop,
  output logic [$clog2(CDC_DEPTH):0]   cdc_level
);

  arb_state_e  state_q, state_d;
  logic [11:0] sent_q, sent_d;
  logic [11:0] len_q, len_d;
  logic        pktdone_q, pktdone_d;
  logic [11:0] cdc_avail, commit_cnt;
  logic        pop_ok, fifo_pop, fifo_commit, fifo_rewind;
  logic [7:0]  fifo_rd;

  cdc_tx_fifo #(.DEPTH(CDC_DEPTH)) u_fifo (
    .clk        (hclk),
    .rst        (hreset),
    .push       (cdc_in_tvalid),
    .push_data  (cdc_in_tdata),
    .pop        (fifo_pop),
    .commit     (fifo_commit),
    .commit_cnt (commit_cnt),
    .rewind     (fifo_rewind),
    .rd_data    (fifo_rd),
    .level      (cdc_level),
    .drop       (cdc_drop)
  );

  always_comb begin
    cdc_avail   = (12'(cdc_level) > CDC_MAX_PKT) ? CDC_MAX_PKT : 12'(cdc_level);
    pop_ok      = usb_txpop & (state_q != ST_IDLE) & (sent_q < len_q);
    dap_tready  = pop_ok & (state_q == ST_DAP);
    fifo_pop    = pop_ok & (state_q == ST_CDC);
    commit_cnt  = sent_q + 12'(pop_ok);
    state_d     = state_q;
    sent_d      = commit_cnt;
    len_d       = len_q;
    pktdone_d   = 1'b0;
    fifo_commit = 1'b0;
    fifo_rewind = 1'b0;
    usb_txcork  = 1'b1;
    usb_txlen   = '0;
    usb_txdata  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (usb_endpt == DAP_EP) begin
          usb_txcork = ~dap_tvalid;
          usb_txlen  = dap_tlen;
          if (usb_txact && dap_tvalid) begin
            state_d = ST_DAP;
            len_d   = dap_tlen;
            sent_d  = '0;
          end
        end else if (usb_endpt == CDC_EP) begin
          usb_txcork = (cdc_level == '0);
          usb_txlen  = cdc_avail;
          if (usb_txact && cdc_level != '0) begin
            state_d = ST_CDC;
            len_d   = cdc_avail;
            sent_d  = '0;
          end
        end
      end
      ST_DAP: begin
        usb_txcork = 1'b0;
        usb_txlen  = len_q;
        usb_txdata = dap_tdata;
        if (usb_txpktfin) begin
          pktdone_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (!usb_txact) begin
          state_d = ST_IDLE;
        end
      end
      ST_CDC: begin
        usb_txcork = 1'b0;
        usb_txlen  = len_q;
        usb_txdata = fifo_rd;
        if (usb_txpktfin) begin
          fifo_commit = 1'b1;
          state_d     = ST_IDLE;
        end else if (!usb_txact) begin
          fifo_rewind = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= ST_IDLE;
      sent_q    <= '0;
      len_q     <= '0;
      pktdone_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sent_q    <= sent_d;
      len_q     <= len_d;
      pktdone_q <= pktdone_d;
    end
  end

  assign dap_pktdone = pktdone_q;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Directed and randomized checks of usb_tx_arbiter against a queue-based
// packet model of the DAP/CDC IN arbitration rules.
module tb_usb_tx_arbiter;

  localparam int DAP_EP = 2;
  localparam int CDC_EP = 3;
  localparam int DEPTH  = 64;
  localparam int MAXP   = 64;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic [3:0]  usb_endpt = '0;
  logic        usb_txact = 1'b0, usb_txpop = 1'b0, usb_txpktfin = 1'b0;
  logic        usb_txcork;
  logic [7:0]  usb_txdata;
  logic [11:0] usb_txlen;
  logic        dap_tvalid = 1'b0;
  logic [7:0]  dap_tdata = '0;
  logic [11:0] dap_tlen = '0;
  logic        dap_tready, dap_pktdone;
  logic        cdc_in_tvalid = 1'b0;
  logic [7:0]  cdc_in_tdata = '0;
  logic        cdc_drop;
  logic [6:0]  cdc_level;

  usb_tx_arbiter #(
    .DAP_EP(4'd2), .CDC_EP(4'd3), .CDC_DEPTH(64), .CDC_MAX_PKT(12'd64)
  ) dut (
    .hclk(hclk), .hreset(hreset), .usb_endpt(usb_endpt), .usb_txact(usb_txact),
    .usb_txpop(usb_txpop), .usb_txpktfin(usb_txpktfin), .usb_txcork(usb_txcork),
    .usb_txdata(usb_txdata), .usb_txlen(usb_txlen), .dap_tvalid(dap_tvalid),
    .dap_tdata(dap_tdata), .dap_tlen(dap_tlen), .dap_tready(dap_tready),
    .dap_pktdone(dap_pktdone), .cdc_in_tvalid(cdc_in_tvalid),
    .cdc_in_tdata(cdc_in_tdata), .cdc_drop(cdc_drop), .cdc_level(cdc_level)
  );

  always #5 hclk = ~hclk;

  int checks = 0;
  int errors = 0;

  // Reference model: committed FIFO contents as a queue, packet mode 0/1/2
  // meaning none / DAP packet / CDC packet.
  logic [7:0] q[$];
  int m_mode = 0, m_len = 0, m_sent = 0;
  bit exp_drop = 0, exp_done = 0;

  int s_cork, s_len, s_data, s_level;
  int tready_cnt = 0, drop_cnt = 0, done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int exp_cork, exp_len, exp_data, exp_tready, sz;
    bit data_known, full, acc;
    #1;
    sz = q.size();
    exp_tready = 0;
    data_known = 1;
    exp_data   = 0;
    if (m_mode == 0) begin
      if (usb_endpt == DAP_EP) begin
        exp_cork = !dap_tvalid; exp_len = dap_tlen;
      end else if (usb_endpt == CDC_EP) begin
        exp_cork = (sz == 0); exp_len = (sz > MAXP) ? MAXP : sz;
      end else begin
        exp_cork = 1; exp_len = 0;
      end
    end else begin
      exp_cork = 0;
      exp_len  = m_len;
      if (m_mode == 1) begin
        exp_data   = dap_tdata;
        exp_tready = (usb_txpop && m_sent < m_len) ? 1 : 0;
      end else begin
        data_known = (m_sent < m_len);
        if (data_known) exp_data = q[m_sent];
      end
    end
    s_cork = usb_txcork; s_len = usb_txlen; s_data = usb_txdata;
    chk("txcork", usb_txcork, exp_cork);
    chk("txlen", usb_txlen, exp_len);
    chk("dap_tready", dap_tready, exp_tready);
    if (data_known) chk("txdata", usb_txdata, exp_data);
    if (dap_tready) tready_cnt++;

    full = (sz == DEPTH);
    if (hreset) begin
      q.delete(); m_mode = 0; m_len = 0; m_sent = 0; exp_drop = 0; exp_done = 0;
    end else begin
      exp_drop = cdc_in_tvalid && full;
      exp_done = 0;
      if (m_mode == 0) begin
        if (usb_txact && usb_endpt == DAP_EP && dap_tvalid) begin
          m_mode = 1; m_len = dap_tlen; m_sent = 0;
        end else if (usb_txact && usb_endpt == CDC_EP && sz != 0) begin
          m_mode = 2; m_len = (sz > MAXP) ? MAXP : sz; m_sent = 0;
        end
      end else begin
        acc = usb_txpop && (m_sent < m_len);
        if (acc) m_sent++;
        if (usb_txpktfin) begin
          if (m_mode == 1) exp_done = 1;
          else repeat (m_sent) void'(q.pop_front());
          m_mode = 0;
        end else if (!usb_txact) begin
          m_mode = 0;
        end
      end
      if (cdc_in_tvalid && !full) q.push_back(cdc_in_tdata);
    end

    @(posedge hclk);
    @(negedge hclk);
    s_level = cdc_level;
    if (cdc_drop) drop_cnt++;
    if (dap_pktdone) done_cnt++;
    chk("cdc_level", cdc_level, q.size());
    chk("cdc_drop", cdc_drop, exp_drop);
    chk("dap_pktdone", dap_pktdone, exp_done);
  endtask

  task automatic push_bytes(input int unsigned n, input logic [7:0] base);
    for (int unsigned i = 0; i < n; i++) begin
      cdc_in_tvalid = 1'b1;
      cdc_in_tdata  = base + 8'(i);
      tick();
    end
    cdc_in_tvalid = 1'b0;
  endtask

  task automatic pops(input int unsigned n);
    usb_txpop = 1'b1;
    for (int unsigned i = 0; i < n; i++) tick();
    usb_txpop = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    tick();
    hreset = 1'b0;
    chk("rst_level", s_level, 0);
    chk("rst_txdata", s_data, 0);

    // Basic CDC packet of 10 bytes
    push_bytes(10, 8'h00);
    usb_endpt = 4'd3; usb_txact = 1'b1;
    tick();
    chk("cdc10_cork", s_cork, 0);
    chk("cdc10_len", s_len, 10);
    pops(10);
    usb_txpktfin = 1'b1; tick();
    usb_txpktfin = 1'b0; usb_txact = 1'b0; tick();
    chk("cdc10_level", s_level, 0);

    // Abandoned packet is resent from the same first byte
    push_bytes(5, 8'h20);
    usb_txact = 1'b1; tick();
    pops(3);
    usb_txact = 1'b0; tick();
    chk("retry_level", s_level, 5);
    usb_txact = 1'b1; tick();
    usb_txpop = 1'b1; tick();
    chk("retry_byte0", s_data, 32'h20);
    pops(4);
    usb_txpktfin = 1'b1; tick();
    usb_txpktfin = 1'b0; usb_txact = 1'b0; tick();

    // Overflow: 70 pushes, 6 drops, packet capped at 64
    drop_cnt = 0;
    push_bytes(70, 8'h40);
    tick();
    chk("ovf_drops", drop_cnt, 6);
    usb_txact = 1'b1; tick();
    chk("ovf_len", s_len, 64);
    pops(64);
    usb_txpktfin = 1'b1; tick();
    usb_txpktfin = 1'b0; tick();
    chk("ovf_level", s_level, 0);
    chk("ovf_next_corked", s_cork, 1);
    usb_txact = 1'b0; tick();

    // DAP packet of 3 with 5 pops
    tready_cnt = 0; done_cnt = 0;
    usb_endpt = 4'd2; dap_tlen = 12'd3; dap_tvalid = 1'b1; dap_tdata = 8'h5A;
    usb_txact = 1'b1; tick();
    pops(5);
    chk("dap_tready_cnt", tready_cnt, 3);
    usb_txpktfin = 1'b1; tick();
    usb_txpktfin = 1'b0; usb_txact = 1'b0; tick(); tick();
    chk("dap_done_cnt", done_cnt, 1);
    dap_tvalid = 1'b0;

    // Push coinciding with a commit of 4 at level 8
    usb_endpt = 4'd3;
    push_bytes(8, 8'h80);
    usb_txact = 1'b1; tick();
    pops(4);
    usb_txpktfin = 1'b1; cdc_in_tvalid = 1'b1; cdc_in_tdata = 8'hEE; tick();
    usb_txpktfin = 1'b0; cdc_in_tvalid = 1'b0;
    chk("push_commit_level", s_level, 5);
    usb_txact = 1'b0; tick();

    // Reset in the middle of a CDC packet
    usb_txact = 1'b1; tick();
    pops(2);
    hreset = 1'b1; tick();
    hreset = 1'b0; usb_txact = 1'b0; tick();
    chk("midrst_level", s_level, 0);

    // Unserved endpoint stays corked
    usb_endpt = 4'd1; usb_txact = 1'b1; tick();
    chk("ep1_cork", s_cork, 1);
    chk("ep1_len", s_len, 0);
    tick();
    chk("ep1_still_idle", s_cork, 1);
    usb_txact = 1'b0; tick();

    // Randomized traffic
    for (int unsigned c = 0; c < 3000; c++) begin
      if (c % 24 == 0) usb_endpt = 4'($urandom_range(1, 3));
      hreset        = ($urandom % 300 == 0);
      usb_txact     = ($urandom % 10 != 0);
      usb_txpop     = $urandom % 2;
      usb_txpktfin  = ($urandom % 16 == 0);
      dap_tvalid    = $urandom % 2;
      dap_tdata     = 8'($urandom);
      dap_tlen      = 12'($urandom_range(0, 6));
      cdc_in_tvalid = ($urandom % 3 != 0);
      cdc_in_tdata  = 8'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
